// File: rtl/pio_instruct_queue_if.sv
// Avalon-MM slave port plus coprocessor instruction handshake for pio_instruct_queue.
// The slave modport is the queue side; the master modport is the HPS/coprocessor side.
interface pio_instruct_queue_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [2:0]            address;
   logic                  chipselect;
   logic                  write_n;
   logic [31:0]           writedata;
   logic [31:0]           readdata;
   logic [DATA_WIDTH-1:0] ins_data;
   logic                  ins_valid;
   logic                  ins_ready;
   logic                  done;

   modport slave (
      input  address, chipselect, write_n, writedata, ins_ready, done,
      output readdata, ins_data, ins_valid
   );

   modport master (
      output address, chipselect, write_n, writedata, ins_ready, done,
      input  readdata, ins_data, ins_valid
   );
endinterface

// File: rtl/pio_instruct_queue.sv
// HPS-writable instruction FIFO feeding a registered valid/ready output stage,
// with load/set/clear control register, sticky overflow and a done counter.
module pio_instruct_queue #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter logic        CTRL_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   pio_instruct_queue_if.slave   bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [2:0] {
      REG_PUSH     = 3'd0,
      REG_STATUS   = 3'd1,
      REG_CTRL     = 3'd2,
      REG_DONECNT  = 3'd3,
      REG_CTRL_SET = 3'd4,
      REG_CTRL_CLR = 3'd5
   } reg_addr_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] push_shadow;
   logic [DATA_WIDTH-1:0] stage_data;
   logic                  stage_valid;
   logic                  ovf;
   logic                  en;
   logic [15:0]           donecnt;

   logic                  wr_en;
   logic                  push_wr;
   logic                  ovf_clr;
   logic                  ctrl_load;
   logic                  ctrl_set;
   logic                  ctrl_clr;
   logic                  dcnt_clr;
   logic                  en_next;
   logic                  flush;
   logic                  full;
   logic                  empty;
   logic                  accept;
   logic                  ovf_set;
   logic                  transfer;
   logic                  load;
   logic                  unused_wd;

   assign wr_en     = bus.chipselect & ~bus.write_n;
   assign unused_wd = ^bus.writedata;

   always_comb begin
      push_wr   = 1'b0;
      ovf_clr   = 1'b0;
      ctrl_load = 1'b0;
      ctrl_set  = 1'b0;
      ctrl_clr  = 1'b0;
      dcnt_clr  = 1'b0;
      if (wr_en) begin
         case (reg_addr_t'(bus.address))
            REG_PUSH:     push_wr   = 1'b1;
            REG_STATUS:   ovf_clr   = bus.writedata[2];
            REG_CTRL:     ctrl_load = 1'b1;
            REG_DONECNT:  dcnt_clr  = 1'b1;
            REG_CTRL_SET: ctrl_set  = 1'b1;
            REG_CTRL_CLR: ctrl_clr  = 1'b1;
            default:      ;
         endcase
      end
   end

   // FLUSH is never stored: it acts only on the edge of the write that sets it.
   always_comb begin
      en_next = en;
      if (ctrl_load)     en_next = bus.writedata[0];
      else if (ctrl_set) en_next = en | bus.writedata[0];
      else if (ctrl_clr) en_next = en & ~bus.writedata[0];
   end

   assign flush    = (ctrl_load | ctrl_set) & bus.writedata[1];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign accept   = push_wr & ~full;
   assign ovf_set  = push_wr & full;
   assign transfer = stage_valid & bus.ins_ready;
   assign load     = en & ~empty & (~stage_valid | transfer);

   always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= bus.writedata[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         push_shadow <= '0;
         stage_data  <= '0;
         stage_valid <= 1'b0;
         ovf         <= 1'b0;
         en          <= CTRL_RESET;
         donecnt     <= '0;
      end else begin
         en <= en_next;

         if (accept) push_shadow <= bus.writedata[DATA_WIDTH-1:0];

         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;

         if (dcnt_clr)      donecnt <= {15'd0, bus.done};
         else if (bus.done) donecnt <= donecnt + 16'd1;

         if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            stage_data  <= '0;
            stage_valid <= 1'b0;
         end else begin
            if (accept) wptr <= wptr + PW'(1);
            if (load)   rptr <= rptr + PW'(1);
            if (accept && !load)      count <= count + CW'(1);
            else if (!accept && load) count <= count - CW'(1);

            if (load) begin
               stage_data  <= mem[rptr];
               stage_valid <= 1'b1;
            end else if (transfer) begin
               stage_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.ins_data  = stage_data;
   assign bus.ins_valid = stage_valid;

   always_comb begin
      bus.readdata = '0;
      case (reg_addr_t'(bus.address))
         REG_PUSH:    bus.readdata = 32'(push_shadow);
         REG_STATUS:  bus.readdata = {16'(count), 12'd0, stage_valid, ovf, full, empty};
         REG_CTRL:    bus.readdata = {30'd0, en, 1'b0};
         REG_DONECNT: bus.readdata = {16'd0, donecnt};
         default:     bus.readdata = '0;
      endcase
   end
endmodule

// File: tb/tb_pio_instruct_queue.sv
// Directed bench for pio_instruct_queue: register map, FIFO issue, overflow,
// enable/hold behaviour, flush, done counter wrap and mid-transfer reset.
module tb_pio_instruct_queue;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic reset;
   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] rd;

   pio_instruct_queue_if #(.DATA_WIDTH(DW)) bus ();

   pio_instruct_queue #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .CTRL_RESET(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      tick(1);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   initial begin
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      bus.ins_ready  = 1'b0;
      bus.done       = 1'b0;
      reset          = 1'b1;
      tick(2);
      reset = 1'b0;

      // reset values of the register map
      bus_read(3'd0, rd); check("rst_push", rd, 32'h0);
      bus_read(3'd1, rd); check("rst_status", rd, 32'h1);
      bus_read(3'd2, rd); check("rst_ctrl", rd, 32'h2);
      bus_read(3'd3, rd); check("rst_donecnt", rd, 32'h0);
      bus_read(3'd4, rd); check("rst_addr4", rd, 32'h0);
      bus_read(3'd5, rd); check("rst_addr5", rd, 32'h0);
      bus_read(3'd7, rd); check("rst_addr7", rd, 32'h0);
      check("rst_valid", 32'(bus.ins_valid), 32'h0);

      // three pushes streamed out with ins_ready held high
      bus.ins_ready = 1'b1;
      bus_write(3'd0, 32'hA1);
      check("lat_valid_n", 32'(bus.ins_valid), 32'h0);
      bus_write(3'd0, 32'hA2);
      check("lat_valid_n1", 32'(bus.ins_valid), 32'h1);
      check("data_a1", bus.ins_data, 32'hA1);
      bus_write(3'd0, 32'hA3);
      check("data_a2", bus.ins_data, 32'hA2);
      tick(1);
      check("data_a3", bus.ins_data, 32'hA3);
      check("valid_a3", 32'(bus.ins_valid), 32'h1);
      tick(1);
      check("drain_valid", 32'(bus.ins_valid), 32'h0);
      bus_read(3'd1, rd); check("drain_status", rd, 32'h1);

      // disable, overfill, then clear OVF
      bus_write(3'd5, 32'h1);
      for (int i = 0; i <= int'(DEPTH); i++) bus_write(3'd0, 32'h100 + 32'(i));
      bus_read(3'd1, rd); check("full_status", rd, 32'h0010_0006);
      check("full_valid", 32'(bus.ins_valid), 32'h0);
      bus_read(3'd0, rd); check("push_shadow", rd, 32'h10F);
      bus_write(3'd1, 32'h4);
      bus_read(3'd1, rd); check("ovf_clear", rd, 32'h0010_0002);

      // enable with ready low: stage holds its word
      bus.ins_ready = 1'b0;
      bus_write(3'd4, 32'h1);
      tick(1);
      check("hold_valid", 32'(bus.ins_valid), 32'h1);
      check("hold_data0", bus.ins_data, 32'h100);
      tick(2);
      check("hold_data1", bus.ins_data, 32'h100);
      bus_read(3'd1, rd); check("hold_status", rd, 32'h000F_0008);
      bus_write(3'd5, 32'h1);
      check("en_off_valid", 32'(bus.ins_valid), 32'h1);
      bus_read(3'd2, rd); check("en_off_ctrl", rd, 32'h0);
      bus.ins_ready = 1'b1;
      tick(1);
      check("en_off_drop", 32'(bus.ins_valid), 32'h0);
      bus_read(3'd1, rd); check("en_off_count", rd, 32'h000F_0000);

      // flush via load register, then flush via set with 5 queued and stage valid
      bus.ins_ready = 1'b0;
      bus_write(3'd2, 32'h2);
      bus_read(3'd1, rd); check("flush_load_status", rd, 32'h1);
      bus_read(3'd2, rd); check("flush_load_ctrl", rd, 32'h0);
      for (int i = 0; i < 6; i++) bus_write(3'd0, 32'h200 + 32'(i));
      bus_write(3'd4, 32'h1);
      tick(1);
      bus_read(3'd1, rd); check("preflush_status", rd, 32'h0005_0008);
      check("preflush_data", bus.ins_data, 32'h200);
      bus_write(3'd4, 32'h2);
      bus_read(3'd1, rd); check("flush_status", rd, 32'h1);
      check("flush_valid", 32'(bus.ins_valid), 32'h0);
      bus_read(3'd2, rd); check("flush_ctrl", rd, 32'h2);
      bus_write(3'd5, 32'h2);
      bus_read(3'd2, rd); check("clr_flush_ctrl", rd, 32'h2);

      // done counter: 3 pulses, clear racing a pulse, then wrap
      bus.done = 1'b1;
      tick(3);
      bus.done = 1'b0;
      bus_read(3'd3, rd); check("donecnt_3", rd, 32'h3);
      bus.done = 1'b1;
      bus_write(3'd3, 32'h0);
      bus.done = 1'b0;
      bus_read(3'd3, rd); check("donecnt_clr_race", rd, 32'h1);
      bus_write(3'd3, 32'h0);
      bus_read(3'd3, rd); check("donecnt_clr", rd, 32'h0);
      bus.done = 1'b1;
      tick(65535);
      bus.done = 1'b0;
      bus_read(3'd3, rd); check("donecnt_max", rd, 32'hFFFF);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      bus_read(3'd3, rd); check("donecnt_wrap", rd, 32'h0);

      // reset during a pending transfer
      bus.ins_ready = 1'b0;
      bus_write(3'd0, 32'h55);
      tick(1);
      check("pre_rst_data", bus.ins_data, 32'h55);
      bus.ins_ready = 1'b1;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_rst_valid", 32'(bus.ins_valid), 32'h0);
      check("mid_rst_data", bus.ins_data, 32'h0);
      bus_read(3'd0, rd); check("mid_rst_push", rd, 32'h0);
      bus_read(3'd1, rd); check("mid_rst_status", rd, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pio_instruct_queue.md
# pio_instruct_queue

Avalon-MM slave that queues coprocessor instruction words written by the HPS and issues them one at a time over a valid/ready handshake. It is the parametrised successor of the single-register instruction PIO. It keeps the write-to-load, set-bit and clear-bit register semantics on its control register. It adds a DEPTH-entry FIFO, a registered output stage, a readable status register, a sticky overflow flag and a coprocessor completion counter. It sits between the lightweight HPS-to-FPGA bridge and the coprocessor instruction decoder.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width; 1..32.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CTRL_RESET, 1, reset value of CTRL[0] (enable).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe; a write happens when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address (read latency 0).
- ins_data  out  DATA_WIDTH  instruction presented to the coprocessor.
- ins_valid  out  1  ins_data is valid.
- ins_ready  in  1  coprocessor accepts the instruction; a transfer happens when ins_valid=1 and ins_ready=1.
- done  in  1  one-cycle completion pulse from the coprocessor.

## Operation
Register map. Unlisted addresses read as 0, and writes to them are ignored.
- Address 0, PUSH. A write enqueues writedata[DATA_WIDTH-1:0] if the FIFO is not full. If the FIFO is full, the word is dropped and OVF is set. A read returns the last accepted word, zero-extended; it is 0 after reset.
- Address 1, STATUS (read):
  - bit 0: EMPTY (FIFO count = 0).
  - bit 1: FULL (count = DEPTH).
  - bit 2: OVF.
  - bit 3: ins_valid.
  - bits 31:16: count.
- Address 1, STATUS (write): writing 1 to bit 2 clears OVF. All other bits are ignored.
- Address 2, CTRL, load. A write loads CTRL[1:0] from writedata[1:0].
  - CTRL[0]: EN.
  - CTRL[1]: FLUSH, self-clearing.
  - A read returns {30'b0, EN, 0}.
- Address 3, DONECNT. A read returns a 16-bit done counter, zero-extended. Any write clears it.
- Address 4, CTRL set: CTRL |= writedata[1:0].
- Address 5, CTRL clear: CTRL &= ~writedata[1:0]. Clearing FLUSH has no effect.

FIFO:
- Circular buffer with wrapping read and write pointers of log2(DEPTH) bits, plus a count from 0 to DEPTH.
- count excludes the output stage.

Output stage:
- Holds one instruction and drives ins_data and ins_valid.
- It loads the FIFO head on a clock edge when EN=1, count>0, and the stage is either empty or transferring in that cycle.
- Once ins_valid is high, it stays high with ins_data stable until a transfer occurs. Clearing EN does not withdraw a presented instruction; it only stops new loads.

FLUSH:
- A write that sets FLUSH clears the FIFO, the pointers and the output stage on the same edge.
- ins_valid=0 and count=0 from the next cycle. FLUSH reads back 0.
- A transfer handshaking in the flush-write cycle is considered delivered.
- OVF, DONECNT and EN are unaffected; only an explicit write changes EN.

DONECNT:
- Increments by 1 on each cycle with done=1 and wraps from 0xFFFF to 0.
- If a clear write and done=1 occur in the same cycle, the result is 1.

Reset: count=0, pointers=0, ins_valid=0, ins_data=0, OVF=0, DONECNT=0, EN=CTRL_RESET, FLUSH=0, PUSH shadow=0. readdata reflects these values.

## Timing
- PUSH write on edge N: the word is in the FIFO and count is incremented after edge N.
- If the FIFO was empty, the stage was idle and EN=1, the output stage loads on edge N+1. ins_valid=1 after N+1, so latency is 2 edges from write to ins_valid.
- Back-to-back transfers with ins_ready held at 1 sustain one instruction per cycle while count>0.
- Same-cycle PUSH and stage load:
  - The count changes by +1-1=0.
  - Full is evaluated before the load, so a PUSH while count=DEPTH is dropped and sets OVF even if a load happens in that cycle.
- A PUSH to an empty FIFO cannot load into the stage in the same cycle; there is no bypass.
- Clearing OVF in the same cycle as an overflowing PUSH leaves OVF=1. Set wins.
- reset=1 mid-transfer aborts on that edge; ins_valid=0 from the next cycle regardless of ins_ready.

## Test plan
- Reset, then read addresses 0-5. Required: 0, 0x00000001, CTRL_RESET<<1, 0, 0, 0; ins_valid=0.
- PUSH 0xA1, 0xA2, 0xA3 with ins_ready=1. Required: ins_valid rises 2 edges after the first write; ins_data is 0xA1, 0xA2, 0xA3 on consecutive cycles; EMPTY=1 at the end.
- EN=0 (write 1 to address 5), then PUSH DEPTH+1 words. Required: STATUS shows FULL=1, OVF=1, count=DEPTH, ins_valid=0. Then write 4 to address 1: OVF=0.
- EN=1 with ins_ready=0. Required: ins_data is held stable. Clear EN while valid: ins_valid stays 1 until ins_ready=1, then drops with count unchanged.
- With 5 queued entries and the stage valid, write 2 to address 4. Required: next cycle count=0, ins_valid=0, EN unchanged.
- Pulse done 3 times, then clear DONECNT in the same cycle as a done pulse. Required: reads of 3, then 1. Pulse done 65536 times from 0: reads 0 (wrap).
